// File: rtl/rmon_stat_ram_if.sv
// Increment / CPU-read bus of the RMON statistics counter store.
// The slave side is the counter store; the master side is the RMON engine plus the CPU.
interface rmon_stat_ram_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int DELTA_WIDTH = 16
);
  logic                   Init_done;
  logic                   Inc_valid;
  logic                   Inc_ready;
  logic [ADDR_WIDTH-1:0]  Inc_addr;
  logic [DELTA_WIDTH-1:0] Inc_delta;
  logic                   Rd_req;
  logic [ADDR_WIDTH-1:0]  Rd_addr;
  logic                   Rd_clr;
  logic                   Rd_ack;
  logic [DATA_WIDTH-1:0]  Rd_data;
  logic                   Ovf;
  logic [ADDR_WIDTH-1:0]  Ovf_addr;

  modport slave (
    output Init_done, Inc_ready, Rd_ack, Rd_data, Ovf, Ovf_addr,
    input  Inc_valid, Inc_addr, Inc_delta, Rd_req, Rd_addr, Rd_clr
  );
  modport master (
    input  Init_done, Inc_ready, Rd_ack, Rd_data, Ovf, Ovf_addr,
    output Inc_valid, Inc_addr, Inc_delta, Rd_req, Rd_addr, Rd_clr
  );
endinterface

// File: rtl/rmon_stat_ram.sv
// RMON statistics counter store: pipelined read-modify-write increments with
// same-address forwarding, CPU read with atomic clear, and a zeroing sweep after reset.
module rmon_stat_ram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int DELTA_WIDTH  = 16,
  parameter int SATURATE     = 0,
  parameter int CLR_ON_RD_EN = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  rmon_stat_ram_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_ptr;
  logic                    init_done_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    inc_acc, rd_acc, clr_acc;
  logic                    s2_vld;
  logic [ADDR_WIDTH-1:0]   s2_addr;
  logic [DATA_WIDTH-1:0]   s2_old;
  logic [DELTA_WIDTH-1:0]  s2_delta;
  logic [DATA_WIDTH:0]     sum_ext;
  logic                    s2_carry;
  logic [DATA_WIDTH-1:0]   s2_sum;
  logic                    s2_hit_inc, s2_hit_rd, clr_hit_inc;
  logic [1:0]              rd_vld_pipe;
  logic [DATA_WIDTH-1:0]   rd_val;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    ovf_q;
  logic [ADDR_WIDTH-1:0]   ovf_addr_q;

  assign inc_acc = bus.Inc_valid & init_done_q;
  assign rd_acc  = bus.Rd_req & init_done_q;
  assign clr_acc = rd_acc & bus.Rd_clr & (CLR_ON_RD_EN != 0);

  assign sum_ext  = {1'b0, s2_old} + (DATA_WIDTH+1)'(s2_delta);
  assign s2_carry = sum_ext[DATA_WIDTH];
  assign s2_sum   = (SATURATE != 0 && s2_carry) ? '1 : sum_ext[DATA_WIDTH-1:0];

  // The op in S2 has not reached memory yet, so a same-address S1 op or read takes its sum.
  assign s2_hit_inc  = s2_vld && (s2_addr == bus.Inc_addr);
  assign s2_hit_rd   = s2_vld && (s2_addr == bus.Rd_addr);
  assign clr_hit_inc = clr_acc && (bus.Rd_addr == bus.Inc_addr);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= INIT;
      sweep_ptr   <= '0;
      init_done_q <= 1'b0;
      s2_vld      <= 1'b0;
      rd_vld_pipe <= '0;
      rd_data_q   <= '0;
      ovf_q       <= 1'b0;
      ovf_addr_q  <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == ADDR_WIDTH'(DEPTH-1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
      init_done_q <= (state == RUN);
      s2_vld      <= inc_acc;
      rd_vld_pipe <= {rd_vld_pipe[0], rd_acc};
      if (rd_vld_pipe[0]) rd_data_q <= rd_val;
      ovf_q <= s2_vld & s2_carry;
      if (s2_vld && s2_carry) ovf_addr_q <= s2_addr;
    end
  end

  // Datapath registers need no reset: their valid bits gate every use.
  always_ff @(posedge Clk) begin
    if (inc_acc) begin
      s2_addr  <= bus.Inc_addr;
      s2_delta <= bus.Inc_delta;
      s2_old   <= clr_hit_inc ? '0 : (s2_hit_inc ? s2_sum : mem[bus.Inc_addr]);
    end
    if (rd_acc) rd_val <= s2_hit_rd ? s2_sum : mem[bus.Rd_addr];
  end

  // Clear is written after the S2 write so it wins on an address collision.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (state == INIT) begin
        mem[sweep_ptr] <= '0;
      end else begin
        if (s2_vld)  mem[s2_addr]     <= s2_sum;
        if (clr_acc) mem[bus.Rd_addr] <= '0;
      end
    end
  end

  assign bus.Init_done = init_done_q;
  assign bus.Inc_ready = init_done_q;
  assign bus.Rd_ack    = rd_vld_pipe[1];
  assign bus.Rd_data   = rd_data_q;
  assign bus.Ovf       = ovf_q;
  assign bus.Ovf_addr  = ovf_addr_q;
endmodule

// File: tb/tb_rmon_stat_ram.sv
// Directed bench for rmon_stat_ram: a 32-bit wrap instance for the main table and
// sweep/reset sequences, plus 8-bit wrap and saturate instances for overflow corners.
module tb_rmon_stat_ram;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rmon_stat_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DELTA_WIDTH(16)) ba ();
  rmon_stat_ram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(AW), .DELTA_WIDTH(8))  bw ();
  rmon_stat_ram_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(AW), .DELTA_WIDTH(8))  bs ();

  rmon_stat_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .DELTA_WIDTH(16), .SATURATE(0), .CLR_ON_RD_EN(1))
    dut_a (.Clk(clk), .Reset(rst_n), .bus(ba));
  rmon_stat_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .DELTA_WIDTH(8), .SATURATE(0), .CLR_ON_RD_EN(1))
    dut_w (.Clk(clk), .Reset(rst_n), .bus(bw));
  rmon_stat_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .DELTA_WIDTH(8), .SATURATE(1), .CLR_ON_RD_EN(1))
    dut_s (.Clk(clk), .Reset(rst_n), .bus(bs));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        iv;
    logic [5:0]  ia;
    logic [15:0] id;
    logic        rq;
    logic [5:0]  ra;
    logic        rc;
    logic        eack;
    logic [31:0] ed;
    logic        edc;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic iv, logic [5:0] ia, logic [15:0] id, logic rq, logic [5:0] ra,
                              logic rc, logic eack, logic [31:0] ed, logic edc);
    vec_t v;
    v.iv = iv; v.ia = ia; v.id = id; v.rq = rq; v.ra = ra; v.rc = rc;
    v.eack = eack; v.ed = ed; v.edc = edc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // w: 0 = 32-bit instance, 1 = 8-bit wrap, 2 = 8-bit saturate
  task automatic drv(input int w, input logic iv, input logic [5:0] ia, input logic [15:0] id,
                     input logic rq, input logic [5:0] ra, input logic rc);
    if (w == 0) begin
      ba.Inc_valid = iv; ba.Inc_addr = ia; ba.Inc_delta = id;
      ba.Rd_req = rq; ba.Rd_addr = ra; ba.Rd_clr = rc;
    end else if (w == 1) begin
      bw.Inc_valid = iv; bw.Inc_addr = ia; bw.Inc_delta = id[7:0];
      bw.Rd_req = rq; bw.Rd_addr = ra; bw.Rd_clr = rc;
    end else begin
      bs.Inc_valid = iv; bs.Inc_addr = ia; bs.Inc_delta = id[7:0];
      bs.Rd_req = rq; bs.Rd_addr = ra; bs.Rd_clr = rc;
    end
  endtask

  task automatic idle_all();
    for (int w = 0; w < 3; w++) drv(w, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input int w, input logic [5:0] a, output logic [31:0] d);
    logic ack;
    @(negedge clk);
    drv(w, 1'b0, '0, '0, 1'b1, a, 1'b0);
    @(negedge clk);
    idle_all();
    d = 'x;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ack = (w == 0) ? ba.Rd_ack : ((w == 1) ? bw.Rd_ack : bs.Rd_ack);
      if (ack === 1'b1) begin
        d = (w == 0) ? ba.Rd_data : ((w == 1) ? 32'(bw.Rd_data) : 32'(bs.Rd_data));
        break;
      end
    end
  endtask

  // Call right after releasing reset at a negedge; n counts edges until Init_done is seen.
  task automatic wait_init(input bit junk, output int n, output bit bad);
    n = 0;
    bad = 1'b0;
    if (junk) drv(0, 1'b1, 6'd9, 16'd5, 1'b1, 6'd9, 1'b1);
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ba.Init_done === 1'b1) break;
      if (ba.Rd_ack !== 1'b0 || ba.Inc_ready !== 1'b0) bad = 1'b1;
    end
    idle_all();
  endtask

  initial begin
    logic [31:0] d;
    int n;
    bit bad;

    tbl[0]  = mk(1, 5, 16'd1,    0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 6, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 5, 16'd2,    0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 6, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 5, 16'd3,    0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 6, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 5, 16'd4,    0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 5, 16'd5,    0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 5, 16'd6,    0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 5, 16'd7,    0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 5, 16'd8,    0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 5, 16'd9,    0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 5, 16'd10,   1, 5, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 16'd0,    1, 5, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 16'd0,    1, 6, 0, 1, 32'd45, 1);
    tbl[15] = mk(1, 3, 16'd100,  0, 0, 0, 1, 32'd55, 1);
    tbl[16] = mk(1, 3, 16'd7,    1, 3, 1, 1, 32'h2FFFD, 1);
    tbl[17] = mk(0, 0, 16'd0,    1, 3, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 16'd0,    0, 0, 0, 1, 32'd100, 1);
    tbl[19] = mk(0, 0, 16'd0,    0, 0, 0, 1, 32'd7, 1);
    tbl[20] = mk(0, 0, 16'd0,    0, 0, 0, 0, 32'd7, 1);

    idle_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst Init_done", ba.Init_done, 0);
    chk("rst Inc_ready", ba.Inc_ready, 0);
    chk("rst Rd_ack",    ba.Rd_ack, 0);
    chk("rst Rd_data",   ba.Rd_data, 0);
    chk("rst Ovf",       ba.Ovf, 0);
    chk("rst Ovf_addr",  ba.Ovf_addr, 0);
    rst_n = 1'b1;
    wait_init(1'b0, n, bad);
    chk("init cycles", n, DEPTH + 1);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      chk($sformatf("row%0d Rd_ack", i), ba.Rd_ack, tbl[i].eack);
      chk($sformatf("row%0d Ovf", i), ba.Ovf, 0);
      if (tbl[i].edc) chk($sformatf("row%0d Rd_data", i), ba.Rd_data, tbl[i].ed);
      drv(0, tbl[i].iv, tbl[i].ia, tbl[i].id, tbl[i].rq, tbl[i].ra, tbl[i].rc);
    end
    @(negedge clk);
    idle_all();

    // Overflow: 250 then +10 back-to-back on address 1, both 8-bit instances
    drv(1, 1, 6'd1, 16'd250, 0, 0, 0); drv(2, 1, 6'd1, 16'd250, 0, 0, 0);
    @(negedge clk);
    drv(1, 1, 6'd1, 16'd10, 0, 0, 0);  drv(2, 1, 6'd1, 16'd10, 0, 0, 0);
    @(negedge clk);
    idle_all();
    chk("wrap Ovf T+1", bw.Ovf, 0);
    chk("sat Ovf T+1",  bs.Ovf, 0);
    @(negedge clk);
    chk("wrap Ovf T+2",      bw.Ovf, 1);
    chk("wrap Ovf_addr T+2", bw.Ovf_addr, 1);
    chk("sat Ovf T+2",       bs.Ovf, 1);
    chk("sat Ovf_addr T+2",  bs.Ovf_addr, 1);
    drv(2, 1, 6'd1, 16'd0, 0, 0, 0);
    @(negedge clk);
    idle_all();
    @(negedge clk);
    chk("sat all-ones +0 no Ovf", bs.Ovf, 0);
    rd(1, 6'd1, d); chk("wrap read addr1", d, 32'd4);
    rd(2, 6'd1, d); chk("sat read addr1",  d, 32'd255);

    // Reset one cycle after accepting increments, with reads in flight
    @(negedge clk);
    drv(0, 1, 6'd2, 16'd9, 1, 6'd2, 0);
    drv(1, 1, 6'd1, 16'd255, 1, 6'd1, 0);
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst Init_done", ba.Init_done, 0);
    chk("midrst Inc_ready", ba.Inc_ready, 0);
    chk("midrst Rd_ack",    ba.Rd_ack, 0);
    chk("midrst Rd_data",   ba.Rd_data, 0);
    chk("midrst Ovf",       ba.Ovf, 0);
    chk("midrst w Rd_ack",  bw.Rd_ack, 0);
    chk("midrst w Ovf",     bw.Ovf, 0);
    chk("midrst w Ovf_addr", bw.Ovf_addr, 0);
    @(negedge clk);
    chk("midrst w Ovf late", bw.Ovf, 0);
    rst_n = 1'b1;
    wait_init(1'b0, n, bad);
    chk("midrst Init_done after sweep", ba.Init_done, 1);
    rd(0, 6'd2, d); chk("midrst read addr2",   d, 0);
    rd(1, 6'd1, d); chk("midrst w read addr1", d, 0);

    // Garbage everywhere, then a full reset sweep with traffic offered during it
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drv(0, 1, 6'(i), 16'(i * 37 + 1), 0, 0, 0);
    end
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init(1'b1, n, bad);
    chk("sweep init cycles", n, DEPTH + 1);
    chk("sweep no ack / ready low", bad, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(0, 6'(i), d);
      chk($sformatf("sweep read addr%0d", i), d, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rmon_stat_ram.md
# rmon_stat_ram

Parameterised statistics-counter store for the RMON block. It is the successor to the plain RMON dual-port RAM. The RMON engine issues increment requests and the block performs the read-modify-write internally, with pipelining and same-address forwarding. The CPU port reads counters, optionally clearing them atomically. Counter width, depth, delta width and overflow mode are parameters, and a built-in sweep zeroes every entry after reset.

## Interface
- DATA_WIDTH, 32, counter width in bits
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH entries
- DELTA_WIDTH, 16, increment operand width (must be ≤ DATA_WIDTH)
- SATURATE, 0, overflow mode: 0 = wrap modulo 2**DATA_WIDTH, 1 = clamp at all-ones
- CLR_ON_RD_EN, 1, 1 = Rd_clr honoured; 0 = Rd_clr ignored

Ports:
- Clk  in  1  single clock for all logic
- Reset  in  1  synchronous, active-low reset
- Init_done  out  1  high once the zeroing sweep is complete
- Inc_valid  in  1  increment request
- Inc_ready  out  1  request accepted when Inc_valid && Inc_ready
- Inc_addr  in  ADDR_WIDTH  counter index
- Inc_delta  in  DELTA_WIDTH  amount to add, zero-extended
- Rd_req  in  1  CPU read request, one-cycle strobe
- Rd_addr  in  ADDR_WIDTH  counter index to read
- Rd_clr  in  1  clear counter as part of this read
- Rd_ack  out  1  one-cycle pulse; Rd_data valid
- Rd_data  out  DATA_WIDTH  counter value returned
- Ovf  out  1  one-cycle pulse: an increment wrapped or saturated
- Ovf_addr  out  ADDR_WIDTH  index that overflowed; valid with Ovf

## Operation
- FSM states:
  - INIT: Reset low forces INIT with sweep pointer 0. Once Reset is high, the FSM writes 0 to one address per cycle, 0..DEPTH-1, then moves to RUN.
  - RUN: normal operation. Only Reset low leaves RUN.
- Inc_ready = Init_done, and is never deasserted in RUN. Rd_req while Init_done = 0 is dropped, with no Rd_ack.
- Increment pipeline, for a request accepted at cycle T:
  - S1 at T: memory read issued.
  - S2 at T+1: sum = old + delta.
  - Write at the T+2 edge.
- Forwarding: any accepted increment sees the result of every earlier accepted increment or clear to the same address, including ones still in S1/S2. Back-to-back same-address requests at full rate must be exact.
- Arithmetic:
  - SATURATE=0: result = (old + delta) mod 2**DATA_WIDTH. Ovf pulses when a carry out occurs.
  - SATURATE=1: result = min(old + delta, 2**DATA_WIDTH-1). Ovf pulses when clamping changed the result; no pulse if old was already all-ones and delta = 0.
- CPU read: one request per cycle may be accepted, fully pipelined.
  - The returned value includes exactly the increments accepted in cycles before the Rd_req cycle.
  - An increment accepted in the same cycle as Rd_req to the same address is not included.
- Clear-on-read (Rd_clr=1, CLR_ON_RD_EN=1): the counter becomes 0 atomically with the read. That same-cycle increment, and any later ones, accumulate from 0, so no count is lost or double-counted.
- Reset mid-operation: in-flight increments and reads are discarded, no Rd_ack or Ovf is issued, and the sweep restarts.

## Timing
- Reset values (cycle after Reset sampled low): Init_done=0, Inc_ready=0, Rd_ack=0, Rd_data=0, Ovf=0, Ovf_addr=0.
- Init_done rises the cycle after the write to address DEPTH-1, i.e. DEPTH+1 cycles after Reset is first sampled high.
- Increment latency: visible to a CPU read issued at T+1 or later (via forwarding). Ovf/Ovf_addr registered, asserted in cycle T+2.
- Read latency: Rd_req at T gives Rd_ack=1 and Rd_data in cycle T+2. Rd_data holds its value until the next Rd_ack.
- Throughput: 1 increment and 1 read per cycle, simultaneously, with no stalls.

## Test plan
- Reset sweep:
  - Preload memory with garbage, then hold Reset low for 3 cycles.
  - Required: Init_done rises exactly DEPTH+1 cycles after release; reading all 64 addresses returns 0.
- Back-to-back same address:
  - 10 consecutive increments to address 5, delta = 1..10.
  - Required: a read gives 55.
  - Interleave with address 6, delta 0xFFFF ×3; required: 0x2FFFD.
- Overflow:
  - DATA_WIDTH=8, SATURATE=0: address 1 at 250, +10 gives 4, with Ovf=1 and Ovf_addr=1 at T+2.
  - SATURATE=1: the same stimulus gives 255, with Ovf=1.
- Clear-on-read race:
  - Address 3 holds 100. Drive Rd_req with Rd_clr=1 and Inc(3, +7) in the same cycle.
  - Required: Rd_data=100 at T+2; the next read gives 7.
- Read before init:
  - Rd_req during the sweep produces no Rd_ack, and Inc_ready=0.
- Reset mid-operation:
  - Assert Reset one cycle after accepting Inc(2, +9).
  - Required: no Ovf or Rd_ack, and address 2 reads 0 after the new sweep.
